// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register peripheral: frame length,
// register map addresses and the frame-decoder state encoding.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input, with an extra
// history flop so rising/falling edges come from synchronized values only.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchronizer chain plus previous-value flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  o_level & ~r_prev;
  assign o_fall  = ~o_level &  r_prev;

endmodule

// File: rtl/spi_reg_peripheral.sv
// Write-only SPI (mode 0) peripheral: decodes 16-bit write frames
// {W, addr[6:0], data[7:0]} and drives five 8-bit configuration registers.
module spi_reg_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04,
  parameter int         FRAME_BITS  = spi_reg_pkg::FRAME_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_ok
);

  import spi_reg_pkg::*;

  // Counter must reach FRAME_BITS+1 so long frames stay distinguishable.
  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi_lvl, w_copi_rise, w_copi_fall;
  logic w_ncs_lvl,  w_ncs_rise,  w_ncs_fall;
  logic w_unused_edges;
  logic w_accept;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_shift;
  logic             r_fall_pend;
  logic [7:0]       r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_pwm_duty;
  logic             r_frame_ok;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_async(copi),
    .o_level(w_copi_lvl), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_async(ncs),
    .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );

  // Only sclk rise, copi level and ncs edges/level drive the decoder.
  assign w_unused_edges = &{1'b0, w_sclk_lvl, w_sclk_fall, w_copi_rise, w_copi_fall};

  assign w_accept = (r_cnt == CNT_FULL) && r_shift[15] && (r_shift[14:8] <= MAX_ADDR);

  // Frame decoder: collect bits between ncs edges, commit for one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_fall_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ncs_fall || r_fall_pend) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_fall_pend <= 1'b0;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          // ncs rise wins over any sclk edge seen in the same clk
          if (w_ncs_rise) begin
            r_state <= COMMIT;
          end else if (w_sclk_rise && !w_ncs_lvl) begin
            r_shift <= {r_shift[14:0], w_copi_lvl};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
          end
        end
        COMMIT: begin
          // A new frame may start while committing; hold its edge for IDLE
          if (w_ncs_fall) r_fall_pend <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Register file write and frame_ok pulse on an accepted commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_out_lo <= 8'h00;
      r_en_out_hi <= 8'h00;
      r_en_pwm_lo <= 8'h00;
      r_en_pwm_hi <= 8'h00;
      r_pwm_duty  <= 8'h00;
      r_frame_ok  <= 1'b0;
    end else begin
      r_frame_ok <= 1'b0;
      if (r_state == COMMIT && w_accept) begin
        r_frame_ok <= 1'b1;
        case (r_shift[14:8])
          ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
          ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
          ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
          ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
          ADDR_PWM_DUTY:  r_pwm_duty  <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_pwm_duty;
  assign frame_ok        = r_frame_ok;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Self-checking bench for spi_reg_peripheral: SPI mode-0 frames driven at
// SCLK = clk/8, compared against a register-map model built from frame rules.
module tb_spi_reg_peripheral;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_ok;

  int checks   = 0;
  int failures = 0;
  int ok_cnt   = 0;
  int exp_ok   = 0;
  logic [7:0] model [5];

  spi_reg_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04), .FRAME_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .frame_ok(frame_ok)
  );

  always #50 clk = ~clk;

  // Count every clk in which frame_ok is seen high
  always @(negedge clk) if (frame_ok === 1'b1) ok_cnt <= ok_cnt + 1;

  function automatic logic [7:0] dut_reg(int i);
    case (i)
      0: return en_reg_out_7_0;
      1: return en_reg_out_15_8;
      2: return en_reg_pwm_7_0;
      3: return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: only an exact 16-bit write frame to address 0..4 takes effect
  task automatic model_frame(logic [31:0] bits, int nbits);
    logic [6:0] a;
    a = bits[14:8];
    if (nbits == 16 && bits[15] && a <= 7'd4) begin
      model[a] = bits[7:0];
      exp_ok++;
    end
  endtask

  task automatic shift_bits(logic [31:0] bits, int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(logic [31:0] bits, int nbits, int gap);
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(bits, nbits);
    wait_clk(4);
    ncs = 1'b1;
    model_frame(bits, nbits);
    wait_clk(gap);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_reg(i) !== 8'h00) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=00", i, dut_reg(i));
      end
    end
    checks++;
    if (frame_ok !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_ok got=%b exp=0", frame_ok);
    end
  endtask

  task automatic test_single_write();
    int ok0;
    ok0 = ok_cnt;
    send_frame(32'h80F0, 16, 0);
    wait_clk(SYNC + 1);
    checks++;
    if (en_reg_out_7_0 !== 8'h00) begin
      failures++;
      $display("FAIL early_update got=%h exp=00", en_reg_out_7_0);
    end
    wait_clk(1);
    checks++;
    if (en_reg_out_7_0 !== 8'hF0 || frame_ok !== 1'b1) begin
      failures++;
      $display("FAIL latency_update reg=%h ok=%b exp=F0/1", en_reg_out_7_0, frame_ok);
    end
    wait_clk(6);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_reg(i) !== model[i]) begin
        failures++;
        $display("FAIL single_reg%0d got=%h exp=%h", i, dut_reg(i), model[i]);
      end
    end
    checks++;
    if (ok_cnt - ok0 != 1) begin
      failures++;
      $display("FAIL single_pulses got=%0d exp=1", ok_cnt - ok0);
    end
  endtask

  task automatic check_all(string name, int ok0, int exp_delta);
    wait_clk(SYNC + 4);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_reg(i) !== model[i]) begin
        failures++;
        $display("FAIL %s_reg%0d got=%h exp=%h", name, i, dut_reg(i), model[i]);
      end
    end
    checks++;
    if (ok_cnt - ok0 != exp_delta) begin
      failures++;
      $display("FAIL %s_pulses got=%0d exp=%0d", name, ok_cnt - ok0, exp_delta);
    end
  endtask

  task automatic test_two_writes();
    int ok0;
    ok0 = ok_cnt;
    send_frame(32'h8480, 16, 8);
    send_frame(32'h82FF, 16, 0);
    check_all("two_writes", ok0, 2);
  endtask

  task automatic test_back_to_back();
    int ok0;
    ok0 = ok_cnt;
    send_frame(32'h8155, 16, 1);
    send_frame(32'h8333, 16, 0);
    check_all("back_to_back", ok0, 2);
  endtask

  task automatic test_dropped();
    int ok0;
    ok0 = ok_cnt;
    send_frame(32'h01AA, 16, 8);
    send_frame(32'h8555, 16, 8);
    send_frame(32'h40D5, 15, 8);
    send_frame(32'h10354, 17, 0);
    check_all("dropped", ok0, 0);
  endtask

  task automatic test_reset_mid_frame();
    int ok0;
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h833C >> 7, 9);
    rst_n = 1'b0;
    ncs = 1'b1;
    copi = 1'b0;
    wait_clk(2);
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_reg(i) !== 8'h00) begin
        failures++;
        $display("FAIL midreset_reg%0d got=%h exp=00", i, dut_reg(i));
      end
    end
    rst_n = 1'b1;
    ok0 = ok_cnt;
    wait_clk(6);
    send_frame(32'h833C, 16, 0);
    check_all("after_reset", ok0, 1);
  endtask

  task automatic test_ncs_glitch();
    int ok0;
    ok0 = ok_cnt;
    ncs = 1'b0;
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(10);
    send_frame(32'h8011, 16, 0);
    check_all("glitch", ok0, 1);
  endtask

  task automatic test_random();
    int ok0, nb, pick;
    logic [31:0] bits;
    logic [6:0]  a;
    logic        rw;
    for (int n = 0; n < 24; n++) begin
      ok0 = ok_cnt;
      exp_ok = 0;
      a    = 7'($urandom_range(0, 6));
      rw   = ($urandom_range(0, 3) != 0);
      bits = {16'h0, rw, a, 8'($urandom)};
      pick = $urandom_range(0, 5);
      nb   = (pick == 0) ? 15 : (pick == 1) ? 17 : 16;
      if (nb == 15) bits = bits >> 1;
      if (nb == 17) bits = {bits[30:0], 1'($urandom)};
      send_frame(bits, nb, 0);
      check_all("random", ok0, exp_ok);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    wait_clk(3);
    test_reset();
    rst_n = 1'b1;
    wait_clk(4);
    test_single_write();
    test_two_writes();
    test_back_to_back();
    test_dropped();
    test_reset_mid_frame();
    test_ncs_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI peripheral (mode 0, write-only) that sits directly upstream of the PWM peripheral in the top-level user project.
- Receives serial frames on ui_in pins (SCLK, COPI, nCS) in the system clock domain.
- Decodes 16-bit write transactions and drives five 8-bit configuration registers consumed by the PWM/output-enable logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).
- MAX_ADDR, 7'h04, highest valid register address; writes above it are dropped.
- FRAME_BITS, 16, required bit count per transaction (1 R/W + 7 addr + 8 data).

Ports:
- clk  input  1  system clock, 10 MHz nominal.
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock from ui_in[0], asynchronous to clk.
- copi  input  1  SPI data in from ui_in[1], asynchronous.
- ncs  input  1  SPI chip select from ui_in[2], active low, asynchronous.
- en_reg_out_7_0  output  8  register 0x00, output enables uo_out.
- en_reg_out_15_8  output  8  register 0x01, output enables uio_out.
- en_reg_pwm_7_0  output  8  register 0x02, PWM mode select uo_out.
- en_reg_pwm_15_8  output  8  register 0x03, PWM mode select uio_out.
- pwm_duty_cycle  output  8  register 0x04, duty cycle (0x00 = 0 %, 0xFF = 100 %).
- frame_ok  output  1  one-clk pulse when a valid write commits.

Behaviour:
- Reset (async assert, sync deassert by the top level): all five registers = 0x00, frame_ok = 0, bit counter = 0, shift register = 0, FSM = IDLE, synchronizers cleared to sclk=0, copi=0, ncs=1.
- Synchronization: sclk, copi and ncs each pass through a SYNC_STAGES flop chain. One extra flop per signal gives the previous value for edge detection. Rising/falling edges are derived only from synchronized values.
- Input rate: SCLK high and low phases must each be ≥ 3 clk periods; faster SCLK is out of spec.
- FSM states:
  - IDLE: wait for ncs falling edge. On it: clear counter and shift register, go to SHIFT.
  - SHIFT:
    - On each sclk rising edge with ncs low: shift register <= {shift[14:0], copi_sync}, MSB first. The counter increments and saturates at FRAME_BITS+1.
    - On ncs rising edge: go to COMMIT.
    - sclk edges in the same clk as the ncs rising edge are ignored.
  - COMMIT (exactly 1 clk):
    - Accept only if counter == FRAME_BITS, shift[15] == 1 (write), and shift[14:8] <= MAX_ADDR.
    - If accepted: write shift[7:0] to the addressed register and pulse frame_ok; the new register value is visible in that same clk.
    - Otherwise: no register change and no pulse.
    - Always return to IDLE.
- Latency: register update appears SYNC_STAGES+2 clk after the ncs pin rises (synchronizer, edge detection, COMMIT).
- Short frames (<16 bits), long frames (>16 bits), read commands (bit15 = 0) and out-of-range addresses are silently dropped.
- Back-to-back frames: an ncs falling edge arriving while in COMMIT is not lost. IDLE samples the held edge flag; a separate flop latches the falling edge until consumed.
- nCS glitch (low then high with 0 SCLK edges): counter = 0, frame dropped.
- Reset mid-frame: all state clears immediately. Registers return to 0x00, and a partially shifted frame never commits.
- Registers hold their value indefinitely between writes. No read-back path exists; uio_out is not driven by this block.

Decomposition:
- Shared package spi_reg_pkg holds:
  - Register address constants ADDR_EN_OUT_LO = 7'h00 through ADDR_PWM_DUTY = 7'h04.
  - FRAME_BITS.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- One natural sub-module: sync_edge_detect. It is parameterized by SYNC_STAGES and RESET_VAL, takes one async input, and outputs the synchronized level plus rise and fall pulses. It is instantiated three times.

Test Plan:
- Write 0xF0 to 0x00 (bits 1_0000000_11110000), SCLK = clk/8 → en_reg_out_7_0 = 0xF0 within SYNC_STAGES+2 clk of ncs rise; frame_ok pulses once; other registers stay 0x00.
- Write 0x80 to 0x04, then 0xFF to 0x02 back-to-back (ncs high 1 SCLK period) → pwm_duty_cycle = 0x80, en_reg_pwm_7_0 = 0xFF; two frame_ok pulses.
- Read command 0_0000001_10101010, then write to address 0x05 with data 0x55 → all registers unchanged, no frame_ok.
- 15-bit frame and 17-bit frame each targeting 0x01 with 0xAA → en_reg_out_15_8 stays 0x00.
- Assert rst_n low after 9 bits of a write to 0x03, release, then send a full write 0x3C to 0x03 → registers all 0x00 during reset; afterwards en_reg_pwm_15_8 = 0x3C only.
- ncs low/high pulse with no SCLK, then a valid write 0x11 to 0x00 → first pulse ignored; en_reg_out_7_0 = 0x11.
